// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR control slice.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;

    // An all-zero state locks the LFSR, so this replaces a zero seed.
    localparam logic [LFSR_W-1:0] SEED_SAFE = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StPressed,
        StWaitRelease
    } deb_state_e;

    function automatic logic [LFSR_W-1:0] seed_guard(input logic [LFSR_W-1:0] raw);
        return (raw == '0) ? SEED_SAFE : raw;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw button and emits a single-cycle pulse per accepted press.
module btn_debounce
    import lfsr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic pulse_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]     sync_q;
    logic           level;
    deb_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic           pulse_q;

    assign level   = sync_q[1];
    assign pulse_o = pulse_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            pulse_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (level) begin
                        state_q <= StWaitPress;
                        cnt_q   <= '0;
                    end
                end
                StWaitPress: begin
                    if (!level) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StPressed;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StPressed: begin
                    if (!level) begin
                        state_q <= StWaitRelease;
                        cnt_q   <= '0;
                    end
                end
                StWaitRelease: begin
                    // A bounce back to 1 re-arms PRESSED without a second pulse.
                    if (level) begin
                        state_q <= StPressed;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Step/load strobe generation, seed register and step counter for the LFSR.
// Auto-run mode and its prescaler are built only when LFSR_AUTO_RUN_EN is defined.
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_DIV        = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              btn_step_i,
    input  logic              btn_load_i,
    input  logic              sw_auto_i,
    input  logic [LFSR_W-1:0] sw_seed_i,
    output logic              step_o,
    output logic              load_o,
    output logic [LFSR_W-1:0] seed_o,
    output logic [LFSR_W-1:0] step_cnt_o
);

    logic              step_pls, load_pls, step_req;
    logic [LFSR_W-1:0] seed_s1_q, seed_s2_q;
    logic [LFSR_W-1:0] seed_q, seed_d, cnt_q, cnt_d;
    logic              step_q, step_d, load_q, load_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_step (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (btn_step_i),
        .pulse_o(step_pls)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_load (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (btn_load_i),
        .pulse_o(load_pls)
    );

`ifdef LFSR_AUTO_RUN_EN
    localparam int unsigned PrescW = $clog2(AUTO_DIV);
    localparam logic [PrescW-1:0] PrescMax = PrescW'(AUTO_DIV - 1);

    logic [1:0]        auto_sync_q;
    logic              auto_on, presc_wrap;
    logic [PrescW-1:0] presc_q, presc_d;

    assign auto_on    = auto_sync_q[1];
    assign presc_wrap = auto_on && (presc_q == PrescMax);
    assign step_req   = auto_on ? presc_wrap : step_pls;

    // Prescaler idles at 0 outside auto mode so entry always starts a full period.
    always_comb begin
        presc_d = presc_q + PrescW'(1);
        if (load_pls || presc_wrap || !auto_on) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            auto_sync_q <= '0;
            presc_q     <= '0;
        end else begin
            auto_sync_q <= {auto_sync_q[0], sw_auto_i};
            presc_q     <= presc_d;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = sw_auto_i ^ (AUTO_DIV == 0);
    assign step_req    = step_pls;
`endif

    // Load has priority: a coincident step is dropped and the count restarts.
    always_comb begin
        load_d = load_pls;
        step_d = 1'b0;
        seed_d = seed_q;
        cnt_d  = cnt_q;
        if (load_pls) begin
            seed_d = seed_guard(seed_s2_q);
            cnt_d  = '0;
        end else if (step_req) begin
            step_d = 1'b1;
            cnt_d  = cnt_q + LFSR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seed_s1_q <= '0;
            seed_s2_q <= '0;
            seed_q    <= SEED_SAFE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            seed_s1_q <= sw_seed_i;
            seed_s2_q <= seed_s1_q;
            seed_q    <= seed_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            load_q    <= load_d;
        end
    end

    assign step_o     = step_q;
    assign load_o     = load_q;
    assign seed_o     = seed_q;
    assign step_cnt_o = cnt_q;

endmodule
